// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Imported by the fetch buffer and the fetch unit top.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; head is read from registered storage.
// Used both as the fetched-instruction buffer and as the in-flight PC queue.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int AW = (DEPTH > 1) ? clog2(DEPTH) : 1,
  localparam int CW = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] p
  );
    if (32'(p) == DEPTH - 1) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  assign full      = (count_q == CW'(DEPTH));
  assign do_pop    = pop && !flush && (count_q != '0);
  assign do_push   = push && !flush && (!full || do_pop);
  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = nxt(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = nxt(rd_ptr_q);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Credit logic upstream must keep these from ever firing.
  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst)
    !(push && !flush && full && !pop)
  );

  a_no_underflow: assert property (
    @(posedge clk) disable iff (rst)
    !(pop && !flush && (count_q == '0))
  );

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues word requests,
// buffers returned words and presents the head entry to IF/ID.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = RESET_PC_DEF,
  parameter int          FIFO_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] pc_out,
  output logic [31:0] instruction_out,
  output logic        valid_out
);

  localparam int FCW = clog2(FIFO_DEPTH + 1);
  localparam int OCW = clog2(MAX_OUTSTANDING + 1);

  logic [31:0]    fetch_pc_q, fetch_pc_d;
  logic [OCW-1:0] live_q, live_d;
  logic [OCW-1:0] drop_q, drop_d;
  fetch_entry_t   hold_q, hold_d;

  fetch_entry_t   ifq_head;
  fetch_entry_t   ifq_wdata;
  logic [FCW-1:0] ifq_count;
  logic [31:0]    pcq_head;
  logic [OCW-1:0] pcq_count;

  logic rsp_live;
  logic rsp_drop;
  logic req_fire;
  logic credit_ok;
  logic ifq_nonempty;
  logic ifq_pop;
  logic unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];

  assign ifq_nonempty = (ifq_count != '0);
  assign rsp_drop     = imem_rsp_valid && (drop_q != '0);
  assign rsp_live     = imem_rsp_valid && (drop_q == '0);

  // Reserve buffer space for every live request so responses never stall.
  assign credit_ok =
    (32'(live_q) + 32'(ifq_count) < 32'(FIFO_DEPTH)) &&
    (32'(live_q) + 32'(drop_q) < 32'(MAX_OUTSTANDING));

  assign imem_req_valid = !rst && !redirect_valid && credit_ok;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign valid_out = ifq_nonempty && !redirect_valid;
  assign ifq_pop   = valid_out && !stall;

  assign ifq_wdata = '{pc: pcq_head, instr: imem_rsp_data};

  assign pc_out          = ifq_nonempty ? ifq_head.pc
                                        : hold_q.pc;
  assign instruction_out = ifq_nonempty ? ifq_head.instr
                                        : hold_q.instr;

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_ifq (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (rsp_live),
    .push_data (ifq_wdata),
    .pop       (ifq_pop),
    .head_data (ifq_head),
    .count     (ifq_count)
  );

  fetch_fifo #(
    .WIDTH (32),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pcq (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (req_fire),
    .push_data (fetch_pc_q),
    .pop       (rsp_live),
    .head_data (pcq_head),
    .count     (pcq_count)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    live_d     = live_q;
    drop_d     = drop_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      live_d     = '0;
      // Whatever is still live becomes stale and must be discarded.
      drop_d     = drop_q + live_q
                 - OCW'(rsp_live) - OCW'(rsp_drop);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      live_d = live_q + OCW'(req_fire) - OCW'(rsp_live);
      drop_d = drop_q - OCW'(rsp_drop);
    end
  end

  always_comb begin
    hold_d = hold_q;
    if (ifq_nonempty) begin
      hold_d = ifq_head;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      live_q     <= '0;
      drop_q     <= '0;
      hold_q     <= '{pc: 32'h0, instr: INSTR_NOP};
    end else begin
      fetch_pc_q <= fetch_pc_d;
      live_q     <= live_d;
      drop_q     <= drop_d;
      hold_q     <= hold_d;
    end
  end

  a_pcq_tracks_live: assert property (
    @(posedge clk) disable iff (rst)
    pcq_count == live_q
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order memory model
// and a PC/instruction scoreboard.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        stall = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;
  logic        valid_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC        (RST_PC),
    .FIFO_DEPTH      (2),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .stall           (stall),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .pc_out          (pc_out),
    .instruction_out (instruction_out),
    .valid_out       (valid_out)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(
    input logic [31:0] a
  );
    return a ^ 32'hDEAD_BEEF;
  endfunction

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  int          cyc = 0;
  int          last_due = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          rand_ready = 1'b0;
  logic [31:0] exp_req = RST_PC;
  logic [31:0] exp_pc  = RST_PC;
  int          n_consumed = 0;

  // Memory: drives response/ready at +2, commits handshakes at +8.
  always begin
    @(posedge clk);
    cyc++;
    #2;
    imem_rsp_valid = 1'b0;
    if (!rst && mq.size() > 0) begin
      if (mq[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(mq[0].addr);
      end
    end
    imem_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    #6;
    if (rst) begin
      mq.delete();
      last_due = 0;
      exp_req  = RST_PC;
    end else begin
      if (imem_rsp_valid) begin
        void'(mq.pop_front());
      end
      if (redirect_valid) begin
        check("req_in_redirect", 32'(imem_req_valid), 32'd0);
        exp_req = {redirect_pc[31:2], 2'b00};
      end else if (imem_req_valid && imem_req_ready) begin
        int d;
        check("req_addr", imem_req_addr, exp_req);
        exp_req = exp_req + 32'd4;
        d = cyc + $urandom_range(lat_min, lat_max);
        if (d < last_due) d = last_due;
        last_due = d;
        mq.push_back('{addr: imem_req_addr, due: d});
      end
    end
  end

  // Scoreboard on consumed head entries.
  always begin
    @(posedge clk);
    #4;
    if (rst) begin
      exp_pc = RST_PC;
    end else if (redirect_valid) begin
      check("valid_in_redirect", 32'(valid_out), 32'd0);
      exp_pc = {redirect_pc[31:2], 2'b00};
    end else if (valid_out && !stall) begin
      check("sb_pc", pc_out, exp_pc);
      check("sb_instr", instruction_out, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      n_consumed++;
    end
  end

  task automatic cycle(
    input logic        r,
    input logic        rv,
    input logic [31:0] rpc,
    input logic        st
  );
    @(posedge clk);
    #1;
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    stall          = st;
    #3;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int n_before;

    // Reset and first stream with 1-cycle memory
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_valid_out", 32'(valid_out), 32'd0);
    check("rst_pc_out", pc_out, 32'h0);
    check("rst_instr", instruction_out, INSTR_NOP);

    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    check("c1_req_valid", 32'(imem_req_valid), 32'd1);
    check("c1_req_addr", imem_req_addr, 32'h0);
    check("c1_valid_out", 32'(valid_out), 32'd0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    check("c2_req_addr", imem_req_addr, 32'h4);
    check("c2_valid_out", 32'(valid_out), 32'd0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    check("c3_valid_out", 32'(valid_out), 32'd1);
    check("c3_pc", pc_out, 32'h0);
    check("c3_instr", instruction_out, mem_word(32'h0));
    check("c3_credit", 32'(imem_req_valid), 32'd0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    check("c4_pc", pc_out, 32'h4);
    check("c4_req_addr", imem_req_addr, 32'h8);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    check("c5_valid_out", 32'(valid_out), 32'd0);
    check("c5_hold_pc", pc_out, 32'h4);
    check("c5_hold_instr", instruction_out, mem_word(32'h4));
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    check("c6_pc", pc_out, 32'h8);

    // Stall with full buffer
    repeat (6) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      check("stall_req_valid", 32'(imem_req_valid), 32'd0);
      check("stall_valid", 32'(valid_out), 32'd1);
      check("stall_pc", pc_out, exp_pc);
      check("stall_instr", instruction_out, mem_word(exp_pc));
    end
    repeat (6) cycle(1'b0, 1'b0, 32'h0, 1'b0);

    // Redirect with two requests in flight, 3-cycle memory
    repeat (8) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    lat_min = 3;
    lat_max = 3;
    cycle(1'b0, 1'b1, 32'h40, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    check("r1_req_addr", imem_req_addr, 32'h40);
    check("r1_req_valid", 32'(imem_req_valid), 32'd1);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    check("r2_req_addr", imem_req_addr, 32'h44);
    check("r2_req_valid", 32'(imem_req_valid), 32'd1);
    cycle(1'b0, 1'b1, 32'h100, 1'b0);
    check("r3_valid_out", 32'(valid_out), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b0);
      if (valid_out) found = 1'b1;
    end
    check("r3_found", 32'(found), 32'd1);
    check("r3_first_pc", pc_out, 32'h100);
    check("r3_first_instr", instruction_out, mem_word(32'h100));
    repeat (6) cycle(1'b0, 1'b0, 32'h0, 1'b0);

    // Redirect to misaligned target while stalled
    lat_min = 1;
    lat_max = 1;
    repeat (8) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b1, 32'h203, 1'b1);
    check("m_valid_out", 32'(valid_out), 32'd0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    check("m_flushed", 32'(valid_out), 32'd0);
    check("m_req_valid", 32'(imem_req_valid), 32'd1);
    check("m_req_addr", imem_req_addr, 32'h200);
    repeat (6) cycle(1'b0, 1'b0, 32'h0, 1'b0);

    // PC wrap at the top of the address space
    repeat (8) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    check("w_req_top", imem_req_addr, 32'hFFFF_FFFC);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    check("w_req_valid", 32'(imem_req_valid), 32'd1);
    check("w_req_wrap", imem_req_addr, 32'h0);
    repeat (8) cycle(1'b0, 1'b0, 32'h0, 1'b0);

    // Random ready/latency/stall/redirect, reset mid-stream
    rand_ready = 1'b1;
    lat_min    = 1;
    lat_max    = 4;
    for (int i = 0; i < 150; i++) begin
      cycle(1'b0, 1'($urandom_range(0, 19) == 0),
            $urandom(), 1'($urandom_range(0, 3) == 0));
    end
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    check("mr_req_valid", 32'(imem_req_valid), 32'd0);
    check("mr_valid_out", 32'(valid_out), 32'd0);
    check("mr_pc_out", pc_out, 32'h0);
    check("mr_instr", instruction_out, INSTR_NOP);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    check("mr_restart_valid", 32'(imem_req_valid), 32'd1);
    check("mr_restart_addr", imem_req_addr, RST_PC);
    n_before = n_consumed;
    for (int i = 0; i < 150; i++) begin
      cycle(1'b0, 1'($urandom_range(0, 19) == 0),
            $urandom(), 1'($urandom_range(0, 3) == 0));
    end
    check("progress", 32'(n_consumed > n_before + 10), 32'd1);
    repeat (4) cycle(1'b0, 1'b0, 32'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
